multicycle_ctrl: RTL and testbench



---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/multicycle_ctrl_if.sv | 27 ++
 rtl/instr_class.sv | 37 +++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle RV32I (addi/beq/bne) sequencer:
//   - state_t : sequencer FSM states
//   - opcode / funct3 constants for the supported instructions
//   - ALU control encodings and trap cause codes
//   - iclass_t: instruction classification bundle
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_BRANCH,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_NOP = 3'b111;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_t;

    typedef struct packed {
        logic is_addi;
        logic is_beq;
        logic is_bne;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Instruction-memory fetch handshake between the sequencer and the memory.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_ack   : fetch complete, imem_rdata valid this cycle only
//   imem_rdata : fetched instruction word
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_class.sv
// ---------------------------------------------------------------------------
// instr_class
// Purely combinational classifier for the supported RV32I subset.
//   ir      in  DATA_WIDTH  instruction word
//   is_addi out 1           OP-IMM with funct3 = ADD
//   is_beq  out 1           BRANCH with funct3 = BEQ
//   is_bne  out 1           BRANCH with funct3 = BNE
//   illegal out 1           none of the above
// ---------------------------------------------------------------------------
module instr_class
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir,
    output logic                  is_addi,
    output logic                  is_beq,
    output logic                  is_bne,
    output logic                  illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];

    // Only opcode and funct3 take part in classification.
    assign unused_bits = ^{ir[DATA_WIDTH-1:15], ir[11:7]};

    assign is_addi = (opcode == OP_IMM)    && (funct3 == F3_ADD);
    assign is_beq  = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
    assign is_bne  = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
    assign illegal = ~(is_addi | is_beq | is_bne);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle sequencer for an addi/beq/bne datapath. Fetches over a
// variable-latency handshake, latches the instruction (IR) and steps the
// datapath strobes one phase per cycle.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   imem      if   fetch handshake (master modport)
//   stall     in   freeze DECODE/EXEC/WB/BRANCH
//   EQ        in   ALU operands equal
//   instr     out  latched instruction register
//   pc_en     out  PC load strobe
//   PCsrc     out  1 = PC+imm, 0 = PC+4
//   RegWrite  out  register-file write strobe
//   ALUsrc    out  1 = immediate operand
//   ALUctrl   out  000 add, 111 no-op
//   ImmSrc    out  0 = I-type, 1 = B-type
//   halted    out  sticky trap flag
//   cause     out  00 none, 01 illegal, 10 fetch timeout
//   instret   out  retired-instruction count (wraps silently)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_if.master     imem,
    input  logic                  stall,
    input  logic                  EQ,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  pc_en,
    output logic                  PCsrc,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic                  ImmSrc,
    output logic                  halted,
    output logic [1:0]            cause,
    output logic [31:0]           instret
);

    localparam int CW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(FETCH_TIMEOUT);

    state_t                state_reg;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [CW-1:0]         wait_cnt_reg;
    logic [31:0]           instret_reg;
    cause_t                cause_reg;
    logic                  halted_reg;

    // Level outputs are registered from the next state so that they equal a
    // decode of the current state without any combinational path from state.
    logic                  imem_req_reg;
    logic                  alusrc_reg;
    logic [2:0]            aluctrl_reg;
    logic                  immsrc_reg;
    logic                  wb_reg;
    logic                  br_reg;

    iclass_t               cls;

    instr_class #(.DATA_WIDTH(DATA_WIDTH)) u_instr_class (
        .ir      (instr_reg),
        .is_addi (cls.is_addi),
        .is_beq  (cls.is_beq),
        .is_bne  (cls.is_bne),
        .illegal (cls.illegal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH: begin
                // An ack in the last allowed cycle beats the timeout.
                if (imem.imem_ack)
                    state_next = ST_DECODE;
                else if (wait_cnt_reg == WAIT_LIMIT)
                    state_next = ST_TRAP;
            end
            ST_DECODE: begin
                if (!stall) begin
                    if (cls.is_addi)
                        state_next = ST_EXEC;
                    else if (cls.is_beq || cls.is_bne)
                        state_next = ST_BRANCH;
                    else
                        state_next = ST_TRAP;
                end
            end
            ST_EXEC:   if (!stall) state_next = ST_WB;
            ST_WB:     if (!stall) state_next = ST_FETCH;
            ST_BRANCH: if (!stall) state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            instr_reg    <= '0;
            wait_cnt_reg <= '0;
            instret_reg  <= '0;
            cause_reg    <= CAUSE_NONE;
            halted_reg   <= 1'b0;
            imem_req_reg <= 1'b0;
            alusrc_reg   <= 1'b0;
            aluctrl_reg  <= ALU_NOP;
            immsrc_reg   <= 1'b0;
            wb_reg       <= 1'b0;
            br_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == ST_FETCH) begin
                if (imem.imem_ack) begin
                    instr_reg    <= imem.imem_rdata;
                    wait_cnt_reg <= '0;
                end else if (wait_cnt_reg != WAIT_LIMIT) begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
            end

            // Cause is captured once on trap entry and frozen afterwards.
            if (state_next == ST_TRAP && state_reg != ST_TRAP)
                cause_reg <= (state_reg == ST_FETCH) ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;

            if ((state_reg == ST_WB || state_reg == ST_BRANCH) && !stall)
                instret_reg <= instret_reg + 32'd1;

            halted_reg   <= (state_next == ST_TRAP);
            imem_req_reg <= (state_next == ST_FETCH);
            alusrc_reg   <= (state_next == ST_EXEC) || (state_next == ST_WB);
            aluctrl_reg  <= ((state_next == ST_EXEC) || (state_next == ST_WB)) ? ALU_ADD : ALU_NOP;
            immsrc_reg   <= (state_next == ST_BRANCH);
            wb_reg       <= (state_next == ST_WB);
            br_reg       <= (state_next == ST_BRANCH);
        end
    end

    // Write strobes are gated by stall so a held phase never fires twice.
    assign pc_en    = (wb_reg | br_reg) & ~stall;
    assign RegWrite = wb_reg & ~stall;
    assign PCsrc    = br_reg & ((cls.is_beq & EQ) | (cls.is_bne & ~EQ));

    assign imem.imem_req = imem_req_reg;
    assign instr         = instr_reg;
    assign ALUsrc        = alusrc_reg;
    assign ALUctrl       = aluctrl_reg;
    assign ImmSrc        = immsrc_reg;
    assign halted        = halted_reg;
    assign cause         = cause_reg;
    assign instret       = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for the multi-cycle sequencer. The strobe vector packs
// {imem_req, pc_en, PCsrc, RegWrite, ALUsrc, ALUctrl[2:0], ImmSrc, halted,
// cause[1:0]} and is compared against hand-derived per-phase constants.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'hFE209EE3;
    localparam logic [31:0] I_ILL  = 32'h00000033;

    //                            req pc  src rw  asrc alu immS hlt cause
    localparam logic [11:0] S_RESET  = 12'b0_0_0_0_0_111_0_0_00;
    localparam logic [11:0] S_FETCH  = 12'b1_0_0_0_0_111_0_0_00;
    localparam logic [11:0] S_DECODE = 12'b0_0_0_0_0_111_0_0_00;
    localparam logic [11:0] S_EXEC   = 12'b0_0_0_0_1_000_0_0_00;
    localparam logic [11:0] S_WB     = 12'b0_1_0_1_1_000_0_0_00;
    localparam logic [11:0] S_WB_STL = 12'b0_0_0_0_1_000_0_0_00;
    localparam logic [11:0] S_BR_T   = 12'b0_1_1_0_0_111_1_0_00;
    localparam logic [11:0] S_BR_NT  = 12'b0_1_0_0_0_111_1_0_00;
    localparam logic [11:0] S_TR_ILL = 12'b0_0_0_0_0_111_0_1_01;
    localparam logic [11:0] S_TR_TO  = 12'b0_0_0_0_0_111_0_1_10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        EQ;
    logic [31:0] instr;
    logic        pc_en;
    logic        PCsrc;
    logic        RegWrite;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        ImmSrc;
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] instret;
    logic [11:0] strobes;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if #(.DATA_WIDTH(32)) imem_bus ();

    multicycle_ctrl #(.DATA_WIDTH(32), .FETCH_TIMEOUT(15)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem     (imem_bus),
        .stall    (stall),
        .EQ       (EQ),
        .instr    (instr),
        .pc_en    (pc_en),
        .PCsrc    (PCsrc),
        .RegWrite (RegWrite),
        .ALUsrc   (ALUsrc),
        .ALUctrl  (ALUctrl),
        .ImmSrc   (ImmSrc),
        .halted   (halted),
        .cause    (cause),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    assign strobes = {imem_bus.imem_req, pc_en, PCsrc, RegWrite, ALUsrc,
                      ALUctrl, ImmSrc, halted, cause};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s obs=%h exp=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        EQ    = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        // Reset state.
        tick();
        tick();
        chk("rst_strobes", {20'h0, strobes}, {20'h0, S_RESET});
        chk("rst_instr", instr, 32'h0);
        chk("rst_instret", instret, 32'h0);

        // addi with ack tied high.
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = I_ADDI;
        rst_n = 1'b1;
        chk("c0_idle", {20'h0, strobes}, {20'h0, S_RESET});
        tick();
        chk("c1_fetch", {20'h0, strobes}, {20'h0, S_FETCH});
        tick();
        chk("c2_decode", {20'h0, strobes}, {20'h0, S_DECODE});
        chk("addi_ir", instr, I_ADDI);
        tick();
        chk("c3_exec", {20'h0, strobes}, {20'h0, S_EXEC});
        tick();
        chk("c4_wb", {20'h0, strobes}, {20'h0, S_WB});
        chk("wb_instret", instret, 32'd0);
        imem_bus.imem_rdata = I_BEQ;
        tick();
        chk("addi_ret", instret, 32'd1);
        chk("beq_fetch", {20'h0, strobes}, {20'h0, S_FETCH});

        // beq, both EQ values during the BRANCH cycle.
        tick();
        chk("beq_ir", instr, I_BEQ);
        tick();
        EQ = 1'b1; #1;
        chk("beq_taken", {20'h0, strobes}, {20'h0, S_BR_T});
        EQ = 1'b0; #1;
        chk("beq_not_taken", {20'h0, strobes}, {20'h0, S_BR_NT});
        imem_bus.imem_rdata = I_BNE;
        tick();
        chk("beq_ret", instret, 32'd2);

        // bne.
        tick();
        chk("bne_ir", instr, I_BNE);
        tick();
        EQ = 1'b0; #1;
        chk("bne_taken", {20'h0, strobes}, {20'h0, S_BR_T});
        EQ = 1'b1; #1;
        chk("bne_not_taken", {20'h0, strobes}, {20'h0, S_BR_NT});
        imem_bus.imem_rdata = I_ILL;
        tick();
        chk("bne_ret", instret, 32'd3);

        // Illegal instruction traps and holds.
        tick();
        chk("ill_decode", {20'h0, strobes}, {20'h0, S_DECODE});
        tick();
        chk("ill_trap", {20'h0, strobes}, {20'h0, S_TR_ILL});
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("trap_hold", {20'h0, strobes}, {20'h0, S_TR_ILL});
        end
        chk("trap_instret", instret, 32'd3);

        // Reset pulse clears the trap; then withhold ack until timeout.
        rst_n = 1'b0;
        imem_bus.imem_ack = 1'b0;
        #1;
        chk("trap_cleared", {20'h0, strobes}, {20'h0, S_RESET});
        chk("clr_instret", instret, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            chk("to_fetch_wait", {20'h0, strobes}, {20'h0, S_FETCH});
            tick();
        end
        chk("timeout_trap", {20'h0, strobes}, {20'h0, S_TR_TO});
        tick();
        chk("timeout_hold", {20'h0, strobes}, {20'h0, S_TR_TO});

        // Ack on the last allowed wait cycle still decodes.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int k = 1; k < 16; k++) tick();
        chk("bnd_fetch16", {20'h0, strobes}, {20'h0, S_FETCH});
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = I_ADDI;
        tick();
        imem_bus.imem_ack = 1'b0;
        chk("bnd_decode", {20'h0, strobes}, {20'h0, S_DECODE});
        chk("bnd_ir", instr, I_ADDI);

        // Stall held three cycles in WB, then exactly one write-back.
        tick();
        chk("stl_exec", {20'h0, strobes}, {20'h0, S_EXEC});
        tick();
        stall = 1'b1; #1;
        chk("stl_wb_1", {20'h0, strobes}, {20'h0, S_WB_STL});
        tick();
        chk("stl_wb_2", {20'h0, strobes}, {20'h0, S_WB_STL});
        tick();
        chk("stl_wb_3", {20'h0, strobes}, {20'h0, S_WB_STL});
        chk("stl_instret", instret, 32'd0);
        stall = 1'b0; #1;
        chk("stl_release", {20'h0, strobes}, {20'h0, S_WB});
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = I_ADDI;
        tick();
        chk("stl_fetch", {20'h0, strobes}, {20'h0, S_FETCH});
        chk("stl_ret_once", instret, 32'd1);

        // Asynchronous reset in the middle of EXEC.
        tick();
        tick();
        chk("mid_exec", {20'h0, strobes}, {20'h0, S_EXEC});
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {20'h0, strobes}, {20'h0, S_RESET});
        chk("abort_instr", instr, 32'h0);
        chk("abort_instret", instret, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("restart_fetch", {20'h0, strobes}, {20'h0, S_FETCH});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
